// File: rtl/intra_chroma8x8_pred.sv
// intra_chroma8x8_pred
// Front end of the chroma 8x8 mode saver. Accepts one 8x8 chroma block a row at
// a time, together with its top/left neighbours. Builds the V, H and DC
// predictions, then produces clipped per-pixel residues and saturated per-mode SADs.
// Ports:
//   clk, reset (async, active-low)
//   start, mbnumber_in, top, left, top_avail, left_avail  - block setup, taken in IDLE
//   row_valid, row_pix, row_ready                        - source row handshake
//   busy, out_valid                                      - status / one-cycle result strobe
//   mbnumber, sads[0..2]=V/H/DC, vres, hres, dcres       - results, index r*8+c
module intra_chroma8x8_pred #(
   parameter int unsigned BLK  = 8,
   parameter int unsigned SADW = 14
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [8:0]              mbnumber_in,
   input  logic [BLK-1:0][7:0]     top,
   input  logic [BLK-1:0][7:0]     left,
   input  logic                    top_avail,
   input  logic                    left_avail,
   input  logic                    row_valid,
   input  logic [BLK-1:0][7:0]     row_pix,
   output logic                    row_ready,
   output logic                    busy,
   output logic                    out_valid,
   output logic [8:0]              mbnumber,
   output logic [2:0][7:0]         sads,
   output logic [BLK*BLK-1:0][7:0] vres,
   output logic [BLK*BLK-1:0][7:0] hres,
   output logic [BLK*BLK-1:0][7:0] dcres
);

   localparam int unsigned ROWW = 11;   // sum of 8 values of 0..255
   localparam int unsigned DCSW = 12;   // St + Sl + rounding

   typedef enum logic [1:0] {IDLE, LOAD, FINAL, DONE} state_t;

   state_t               state, state_nxt;
   logic                 load_c, accept_c;
   logic [2:0]           row_cnt;
   logic [BLK-1:0][7:0]  top_q, left_q;
   logic                 tav_q, lav_q;
   logic [7:0]           dc_q;
   logic [SADW-1:0]      sad_v, sad_h, sad_dc;

   logic [ROWW-1:0]      st_c, sl_c;
   logic [DCSW-1:0]      both_c;
   logic [ROWW-1:0]      tonly_c, lonly_c;
   logic [7:0]           dc_c;

   logic [7:0]           hp_c;
   logic [BLK-1:0][7:0]  vp_c, vr_c, hr_c, dr_c;
   logic [ROWW-1:0]      vsum_c, hsum_c, dsum_c;

   // Signed difference pix - pred, clipped to the 8-bit two's complement range
   function automatic logic [7:0] clip_res(input logic [7:0] pix, input logic [7:0] pred);
      logic signed [8:0] d;
      d = $signed({1'b0, pix}) - $signed({1'b0, pred});
      if (d > 9'sd127)
         return 8'h7F;
      else if (d < -9'sd128)
         return 8'h80;
      else
         return d[7:0];
   endfunction

   function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   function automatic logic [7:0] sat8(input logic [SADW-1:0] s);
      return (s > SADW'(255)) ? 8'hFF : s[7:0];
   endfunction

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state and handshake decode
   always_comb begin
      state_nxt = state;
      load_c    = 1'b0;
      accept_c  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load_c    = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            if (row_valid) begin
               accept_c = 1'b1;
               if (row_cnt == 3'(BLK - 1))
                  state_nxt = FINAL;
            end
         end
         FINAL:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // DC prediction from the live neighbour inputs, captured together with them on start
   always_comb begin
      st_c = '0;
      sl_c = '0;
      for (int i = 0; i < int'(BLK); i++) begin
         st_c = st_c + ROWW'(top[i]);
         sl_c = sl_c + ROWW'(left[i]);
      end
      both_c  = DCSW'(st_c) + DCSW'(sl_c) + DCSW'(8);
      tonly_c = st_c + ROWW'(4);
      lonly_c = sl_c + ROWW'(4);
      case ({top_avail, left_avail})
         2'b11:   dc_c = 8'(both_c >> 4);
         2'b10:   dc_c = 8'(tonly_c >> 3);
         2'b01:   dc_c = 8'(lonly_c >> 3);
         default: dc_c = 8'd128;
      endcase
   end

   // Residues and absolute-difference sums for the row currently on row_pix
   always_comb begin
      vp_c   = '0;
      vr_c   = '0;
      hr_c   = '0;
      dr_c   = '0;
      vsum_c = '0;
      hsum_c = '0;
      dsum_c = '0;
      hp_c   = lav_q ? left_q[row_cnt] : 8'd128;
      for (int c = 0; c < int'(BLK); c++) begin
         vp_c[c] = tav_q ? top_q[c] : 8'd128;
         vr_c[c] = clip_res(row_pix[c], vp_c[c]);
         hr_c[c] = clip_res(row_pix[c], hp_c);
         dr_c[c] = clip_res(row_pix[c], dc_q);
         vsum_c  = vsum_c + ROWW'(abs_diff(row_pix[c], vp_c[c]));
         hsum_c  = hsum_c + ROWW'(abs_diff(row_pix[c], hp_c));
         dsum_c  = dsum_c + ROWW'(abs_diff(row_pix[c], dc_q));
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_ready <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         row_cnt   <= '0;
         top_q     <= '0;
         left_q    <= '0;
         tav_q     <= 1'b0;
         lav_q     <= 1'b0;
         dc_q      <= '0;
         sad_v     <= '0;
         sad_h     <= '0;
         sad_dc    <= '0;
         mbnumber  <= '0;
         sads      <= '0;
         vres      <= '0;
         hres      <= '0;
         dcres     <= '0;
      end else begin
         row_ready <= (state_nxt == LOAD);
         busy      <= (state_nxt != IDLE);
         out_valid <= (state_nxt == DONE);

         if (load_c) begin
            top_q    <= top;
            left_q   <= left;
            tav_q    <= top_avail;
            lav_q    <= left_avail;
            dc_q     <= dc_c;
            mbnumber <= mbnumber_in;
            row_cnt  <= '0;
            sad_v    <= '0;
            sad_h    <= '0;
            sad_dc   <= '0;
         end

         if (accept_c) begin
            row_cnt <= row_cnt + 3'd1;
            sad_v   <= sad_v + SADW'(vsum_c);
            sad_h   <= sad_h + SADW'(hsum_c);
            sad_dc  <= sad_dc + SADW'(dsum_c);
            for (int c = 0; c < int'(BLK); c++) begin
               vres[{row_cnt, 3'(c)}]  <= vr_c[c];
               hres[{row_cnt, 3'(c)}]  <= hr_c[c];
               dcres[{row_cnt, 3'(c)}] <= dr_c[c];
            end
         end

         // Unavailable neighbours force V/H to the worst score; DC is never forced
         if (state == FINAL) begin
            sads[0] <= tav_q ? sat8(sad_v) : 8'hFF;
            sads[1] <= lav_q ? sat8(sad_h) : 8'hFF;
            sads[2] <= sat8(sad_dc);
         end
      end
   end

endmodule

// File: tb/tb_intra_chroma8x8_pred.sv
// Directed bench for intra_chroma8x8_pred: hand-computed SADs and residues per block.
module tb_intra_chroma8x8_pred;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                start = 1'b0;
   logic [8:0]          mbnumber_in = '0;
   logic [7:0][7:0]     top = '0;
   logic [7:0][7:0]     left = '0;
   logic                top_avail = 1'b0;
   logic                left_avail = 1'b0;
   logic                row_valid = 1'b0;
   logic [7:0][7:0]     row_pix = '0;
   logic                row_ready, busy, out_valid;
   logic [8:0]          mbnumber;
   logic [2:0][7:0]     sads;
   logic [63:0][7:0]    vres, hres, dcres;

   int n_chk = 0;
   int n_err = 0;
   int lat, strobes;

   logic [7:0][7:0]  t_v, l_v;
   logic [63:0][7:0] p_v, ev, eh, ed;

   always #5 clk = ~clk;

   intra_chroma8x8_pred dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .mbnumber_in (mbnumber_in),
      .top         (top),
      .left        (left),
      .top_avail   (top_avail),
      .left_avail  (left_avail),
      .row_valid   (row_valid),
      .row_pix     (row_pix),
      .row_ready   (row_ready),
      .busy        (busy),
      .out_valid   (out_valid),
      .mbnumber    (mbnumber),
      .sads        (sads),
      .vres        (vres),
      .hres        (hres),
      .dcres       (dcres)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic fill(input logic [7:0] tv, input logic [7:0] lv, input logic [7:0] pv);
      for (int i = 0; i < 8; i++) begin
         t_v[i] = tv;
         l_v[i] = lv;
      end
      for (int i = 0; i < 64; i++) p_v[i] = pv;
   endtask

   task automatic set_exp(input logic [7:0] v, input logic [7:0] h, input logic [7:0] d);
      for (int i = 0; i < 64; i++) begin
         ev[i] = v;
         eh[i] = h;
         ed[i] = d;
      end
   endtask

   // Run one block; stall adds 1-3 cycle row gaps plus stray start/row_valid while busy
   task automatic run_block(input logic tav, input logic lav, input logic [8:0] mbn, input bit stall);
      int r, cyc, gap;
      bit xfer;
      top = t_v; left = l_v; top_avail = tav; left_avail = lav; mbnumber_in = mbn;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      top = ~t_v; left = ~l_v; top_avail = ~tav; left_avail = ~lav; mbnumber_in = ~mbn;
      cyc = 1; r = 0; strobes = 0; lat = 0;
      gap = stall ? int'($urandom_range(1, 3)) : 0;
      while (strobes == 0 && cyc < 200) begin
         if (r < 8 && gap == 0) begin
            row_valid = 1'b1;
            for (int c = 0; c < 8; c++) row_pix[c] = p_v[r*8 + c];
         end else begin
            row_valid = stall && (r == 8);
            for (int c = 0; c < 8; c++) row_pix[c] = 8'hEE;
         end
         start = stall && (cyc % 2 == 1);
         xfer = row_valid && row_ready;
         @(posedge clk); #1;
         cyc++;
         if (xfer) begin
            r++;
            if (stall) gap = int'($urandom_range(1, 3));
         end else if (gap > 0) begin
            gap--;
         end
         if (out_valid) begin
            strobes++;
            lat = cyc;
         end
      end
      row_valid = 1'b0;
      start = stall;                      // start during DONE must be dropped
      @(posedge clk); #1;
      start = 1'b0;
      if (out_valid) strobes++;
      if (stall) chk("done_start_ignored busy", 32'(busy), 32'(0));
      repeat (3) begin
         @(posedge clk); #1;
         if (out_valid) strobes++;
      end
      chk("out_valid strobe count", 32'(strobes), 32'(1));
   endtask

   task automatic check_out(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [8:0] mbn);
      chk({tag, " sad_v"},  32'(sads[0]), 32'(s0));
      chk({tag, " sad_h"},  32'(sads[1]), 32'(s1));
      chk({tag, " sad_dc"}, 32'(sads[2]), 32'(s2));
      chk({tag, " mbnumber"}, 32'(mbnumber), 32'(mbn));
      for (int i = 0; i < 64; i++) begin
         chk($sformatf("%s vres[%0d]", tag, i),  32'(vres[i]),  32'(ev[i]));
         chk($sformatf("%s hres[%0d]", tag, i),  32'(hres[i]),  32'(eh[i]));
         chk($sformatf("%s dcres[%0d]", tag, i), 32'(dcres[i]), 32'(ed[i]));
      end
   endtask

   // Gradient block: top=100, left[r]=100+r, pix(r,c)=100+r; DC=(800+828+8)>>4=102
   task automatic gradient_setup();
      fill(8'd100, 8'd100, 8'd0);
      for (int r = 0; r < 8; r++) begin
         l_v[r] = 8'(100 + r);
         for (int c = 0; c < 8; c++) begin
            p_v[r*8 + c] = 8'(100 + r);
            ev[r*8 + c]  = 8'(r);
            eh[r*8 + c]  = 8'd0;
            ed[r*8 + c]  = 8'(r - 2);
         end
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", 32'(busy), 32'(0));
      chk("reset row_ready", 32'(row_ready), 32'(0));
      chk("reset out_valid", 32'(out_valid), 32'(0));
      chk("reset sads", 32'(sads), 32'(0));
      chk("reset mbnumber", 32'(mbnumber), 32'(0));
      reset = 1'b1;
      @(posedge clk); #1;

      // 1. flat block
      fill(8'd100, 8'd100, 8'd100);
      set_exp(8'd0, 8'd0, 8'd0);
      run_block(1'b1, 1'b1, 9'd5, 1'b0);
      chk("flat latency", 32'(lat), 32'(10));
      check_out("flat", 8'd0, 8'd0, 8'd0, 9'd5);

      // 2. vertical stripes: H SAD 2240, DC=18 gives 1504; both saturate
      fill(8'd0, 8'd0, 8'd0);
      for (int c = 0; c < 8; c++) t_v[c] = 8'(10 * c);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            p_v[r*8 + c] = 8'(10 * c);
            ev[r*8 + c]  = 8'd0;
            eh[r*8 + c]  = 8'(10 * c);
            ed[r*8 + c]  = 8'(10 * c - 18);
         end
      run_block(1'b1, 1'b1, 9'd17, 1'b0);
      check_out("stripes", 8'd0, 8'd255, 8'd255, 9'd17);

      // 3. no neighbours
      fill(8'd77, 8'd33, 8'd128);
      set_exp(8'd0, 8'd0, 8'd0);
      run_block(1'b0, 1'b0, 9'd300, 1'b0);
      check_out("none", 8'd255, 8'd255, 8'd0, 9'd300);

      // 4. positive clip and SAD saturation
      fill(8'd0, 8'd0, 8'd255);
      set_exp(8'h7F, 8'h7F, 8'h7F);
      run_block(1'b1, 1'b1, 9'd1, 1'b0);
      check_out("clip_hi", 8'd255, 8'd255, 8'd255, 9'd1);

      // negative clip: DC=(2040+2040+8)>>4=255
      fill(8'd255, 8'd255, 8'd0);
      set_exp(8'h80, 8'h80, 8'h80);
      run_block(1'b1, 1'b1, 9'd2, 1'b0);
      check_out("clip_lo", 8'd255, 8'd255, 8'd255, 9'd2);

      // top only: DC=(1600+4)>>3=200
      fill(8'd200, 8'd9, 8'd200);
      set_exp(8'd0, 8'h48, 8'd0);
      run_block(1'b1, 1'b0, 9'd3, 1'b0);
      check_out("top_only", 8'd0, 8'd255, 8'd0, 9'd3);

      // left only: DC=(400+4)>>3=50, pix 52
      fill(8'd9, 8'd50, 8'd52);
      set_exp(8'hB4, 8'd2, 8'd2);
      run_block(1'b0, 1'b1, 9'd4, 1'b0);
      check_out("left_only", 8'd255, 8'd128, 8'd128, 9'd4);

      // 5. gradient back-to-back then stalled
      gradient_setup();
      run_block(1'b1, 1'b1, 9'd100, 1'b0);
      chk("grad latency", 32'(lat), 32'(10));
      check_out("grad", 8'd224, 8'd0, 8'd144, 9'd100);
      gradient_setup();
      run_block(1'b1, 1'b1, 9'd101, 1'b1);
      check_out("grad_stall", 8'd224, 8'd0, 8'd144, 9'd101);

      // 6. reset during row 4
      gradient_setup();
      top = t_v; left = l_v; top_avail = 1'b1; left_avail = 1'b1; mbnumber_in = 9'd200;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int r = 0; r < 4; r++) begin
         row_valid = 1'b1;
         for (int c = 0; c < 8; c++) row_pix[c] = p_v[r*8 + c];
         @(posedge clk); #1;
      end
      chk("mid busy", 32'(busy), 32'(1));
      for (int c = 0; c < 8; c++) row_pix[c] = p_v[32 + c];
      #2 reset = 1'b0;
      #1;
      chk("rst busy", 32'(busy), 32'(0));
      chk("rst row_ready", 32'(row_ready), 32'(0));
      chk("rst out_valid", 32'(out_valid), 32'(0));
      chk("rst mbnumber", 32'(mbnumber), 32'(0));
      chk("rst vres[8]", 32'(vres[8]), 32'(0));
      chk("rst dcres[0]", 32'(dcres[0]), 32'(0));
      row_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      strobes = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid) strobes++;
      end
      chk("rst no strobe", 32'(strobes), 32'(0));
      gradient_setup();
      run_block(1'b1, 1'b1, 9'd201, 1'b0);
      chk("post_rst latency", 32'(lat), 32'(10));
      check_out("post_rst", 8'd224, 8'd0, 8'd144, 9'd201);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
